// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Each received bit is qualified by rx_valid; reports parity and framing errors per frame.
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  // Counter is one bit wider than strictly needed so it reaches DATA_W without wrapping
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [DATA_W-1:0] data_nx;
  logic              acc, acc_nx;
  logic              perr, perr_nx;
  logic              dv_nx, pe_nx, fe_nx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      acc        <= acc_nx;
      perr       <= perr_nx;
      data_out   <= data_nx;
      data_valid <= dv_nx;
      parity_err <= pe_nx;
      frame_err  <= fe_nx;
    end
  end

  // New bits enter at the MSB so the first data bit ends up in bit 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    acc_nx   = acc;
    perr_nx  = perr;
    data_nx  = data_out;
    dv_nx    = 1'b0;
    pe_nx    = parity_err;
    fe_nx    = frame_err;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (!rx_bit) begin
            state_nx = DATA;
            cnt_nx   = '0;
            shreg_nx = '0;
            acc_nx   = 1'b0;
          end
        end
        DATA: begin
          shreg_nx = (shreg >> 1) | (DATA_W'(rx_bit) << (DATA_W - 1));
          acc_nx   = acc ^ rx_bit;
          cnt_nx   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) state_nx = PARITY;
        end
        PARITY: begin
          perr_nx  = acc ^ rx_bit ^ PARITY_ODD;
          state_nx = STOP;
        end
        STOP: begin
          data_nx  = shreg;
          pe_nx    = perr;
          fe_nx    = ~rx_bit;
          dv_nx    = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomised directed bench for serial_parity_checker: even and odd parity instances
// share one serial line; expected frames come from a word-level model.
module tb_serial_parity_checker;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } frame_t;

  logic clk = 1'b0;
  logic reset, rx_valid, rx_bit;
  logic [DATA_W-1:0] data_out_e, data_out_o;
  logic data_valid_e, parity_err_e, frame_err_e, busy_e;
  logic data_valid_o, parity_err_o, frame_err_o, busy_o;

  int checks = 0;
  int errors = 0;

  frame_t got_e[$], got_o[$], exp_e[$], exp_o[$];
  frame_t last_e, last_o;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(DATA_W), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .data_out(data_out_e), .data_valid(data_valid_e),
    .parity_err(parity_err_e), .frame_err(frame_err_e), .busy(busy_e)
  );

  serial_parity_checker #(.DATA_W(DATA_W), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .data_out(data_out_o), .data_valid(data_valid_o),
    .parity_err(parity_err_o), .frame_err(frame_err_o), .busy(busy_o)
  );

  // Capture every data_valid cycle; a stretched pulse shows up as an extra entry
  always @(negedge clk) begin
    if (data_valid_e === 1'b1) got_e.push_back('{data_out_e, parity_err_e, frame_err_e});
    if (data_valid_o === 1'b1) got_o.push_back('{data_out_o, parity_err_o, frame_err_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    rx_valid = 1'b1;
    rx_bit   = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_bit   = 1'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_stimulus(input logic [DATA_W-1:0] w, input logic pbit, input logic sbit,
                                input int max_gap, input int stop_gap);
    frame_t fe, fo;
    send_bit(1'b0, $urandom_range(max_gap, 0));
    chk("busy_start_even", busy_e, 1);
    chk("busy_start_odd", busy_o, 1);
    for (int i = 0; i < DATA_W; i++) send_bit(w[i], $urandom_range(max_gap, 0));
    send_bit(pbit, $urandom_range(max_gap, 0));
    chk("busy_parity_even", busy_e, 1);
    // Even parity: total ones over data+parity must be even; odd parity: must be odd
    fe = '{w, (^w) ^ pbit, ~sbit};
    fo = '{w, ~((^w) ^ pbit), ~sbit};
    exp_e.push_back(fe);
    exp_o.push_back(fo);
    last_e = fe;
    last_o = fo;
    send_bit(sbit, stop_gap);
    chk("busy_stop_even", busy_e, 0);
    chk("busy_stop_odd", busy_o, 0);
  endtask

  task automatic cmp_q(input string tag, input frame_t got[$], input frame_t exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk({tag, "_data"}, got[i].data, exp[i].data);
      chk({tag, "_perr"}, got[i].perr, exp[i].perr);
      chk({tag, "_ferr"}, got[i].ferr, exp[i].ferr);
    end
  endtask

  task automatic check_output(input string tag);
    repeat (2) begin
      @(posedge clk); #1;
    end
    cmp_q({tag, "_even"}, got_e, exp_e);
    cmp_q({tag, "_odd"}, got_o, exp_o);
    chk({tag, "_hold_data_even"}, data_out_e, last_e.data);
    chk({tag, "_hold_perr_even"}, parity_err_e, last_e.perr);
    chk({tag, "_hold_ferr_even"}, frame_err_e, last_e.ferr);
    chk({tag, "_hold_data_odd"}, data_out_o, last_o.data);
    chk({tag, "_hold_perr_odd"}, parity_err_o, last_o.perr);
    chk({tag, "_dv_low"}, data_valid_e, 0);
    got_e.delete(); got_o.delete(); exp_e.delete(); exp_o.delete();
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_bit   = 1'b1;
    last_e   = '0;
    last_o   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy_even", busy_e, 0);
    chk("reset_busy_odd", busy_o, 0);
    chk("reset_dv_odd", data_valid_o, 0);
    chk("reset_data_even", data_out_e, 0);
    chk("reset_perr_odd", parity_err_o, 0);
    chk("reset_ferr_even", frame_err_e, 0);

    // Start bit immediately in the cycle after reset deasserts
    reset = 1'b0;
    $display("[TB] frame 0xA5 good parity");
    apply_stimulus(8'hA5, 1'b0, 1'b1, 0, 0);
    check_output("a5_good");

    $display("[TB] frame 0xA5 bad parity");
    apply_stimulus(8'hA5, 1'b1, 1'b1, 0, 0);
    check_output("a5_badpar");

    $display("[TB] frame 0x0F bad stop");
    apply_stimulus(8'h0F, 1'b0, 1'b0, 0, 0);
    check_output("0f_badstop");

    $display("[TB] reset mid-frame");
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 1);
    send_bit(1'b1, 0);
    rx_valid = 1'b1;
    rx_bit   = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    chk("midreset_busy_even", busy_e, 0);
    chk("midreset_busy_odd", busy_o, 0);
    last_e = '0;
    last_o = '0;
    check_output("midreset");
    apply_stimulus(8'h3C, 1'b0, 1'b1, 0, 0);
    check_output("3c_after_reset");

    $display("[TB] gaps and back-to-back frames");
    apply_stimulus(8'h01, 1'b1, 1'b1, 5, 0);
    apply_stimulus(8'hFF, 1'b0, 1'b1, 0, 0);
    check_output("b2b");

    $display("[TB] odd parity frame 0x00 and idle strobes");
    apply_stimulus(8'h00, 1'b1, 1'b1, 2, 1);
    check_output("zero_oddpar");
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, i % 2);
      chk("idle_busy_even", busy_e, 0);
      chk("idle_busy_odd", busy_o, 0);
    end
    check_output("idle");

    $display("[TB] random frames");
    for (int n = 0; n < 8; n++) begin
      apply_stimulus(8'($urandom), 1'($urandom), ($urandom_range(3, 0) != 0), 3,
                     $urandom_range(1, 0));
    end
    check_output("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
